// File: rtl/bird_motion.sv
// Purpose: vertical-motion controller for the player bird: signed velocity, gravity,
//          edge-triggered flap impulse, terminal velocity, ceiling/floor clamping, READY/FLY/DEAD FSM.
// Latency: every output is a register; an input change shows up after the first clk10 edge that samples it.
// Backpressure: none; one update per game tick, consumers sample bird_y_pos/state whenever they like.
//
// Ports:
//   clk10      game tick clock, all state changes on its rising edge
//   clr        asynchronous active-high reset
//   game_end   level, pipe collision / game over from the game FSM (kills the bird in FLY)
//   flap       level from debounced button, rising edge = one upward impulse
//   start      level, rising edge launches from READY or re-arms from DEAD
//   bird_y_pos registered top-left y of the bird sprite
//   bird_vel   registered signed velocity (positive = downward)
//   state      READY=0, FLY=1, DEAD=2 (3 behaves as READY)
//   hit_ground one-tick pulse on the tick the floor is reached
module bird_motion #(
  parameter int Y_W      = 10,
  parameter int V_W      = 6,
  parameter int Y_INIT   = 240,
  parameter int Y_MIN    = 15,
  parameter int Y_MAX    = 465,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 8,
  parameter int V_MAX    = 12
) (
  input  logic                  clk10,
  input  logic                  clr,
  input  logic                  game_end,
  input  logic                  flap,
  input  logic                  start,
  output logic [Y_W-1:0]        bird_y_pos,
  output logic signed [V_W-1:0] bird_vel,
  output logic [1:0]            state,
  output logic                  hit_ground
);

  // FSM encoding is visible on the state port, so it stays fixed.
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_FLY   = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  // Position arithmetic runs two bits wider than y: one bit for the sign
  // (a climb above row 0 must not wrap) and one for overshoot past 2^Y_W.
  localparam int P_W = Y_W + 2;

  localparam logic [Y_W-1:0]        Y_INIT_C   = Y_W'(Y_INIT);
  localparam logic [Y_W-1:0]        Y_MIN_C    = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]        Y_MAX_C    = Y_W'(Y_MAX);
  localparam logic signed [P_W-1:0] Y_MIN_X    = P_W'(Y_MIN);
  localparam logic signed [P_W-1:0] Y_MAX_X    = P_W'(Y_MAX);
  localparam logic signed [V_W-1:0] VEL_FLAP   = V_W'(-FLAP_VEL);
  localparam logic signed [V_W-1:0] VEL_MAX_C  = V_W'(V_MAX);
  localparam logic signed [V_W:0]   VEL_MAX_X  = (V_W+1)'(V_MAX);
  localparam logic signed [V_W:0]   GRAVITY_X  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W-1:0] VEL_ZERO   = '0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] vel_q, vel_d;
  logic                  hit_q, hit_d;
  // Previous-tick samples of the buttons, used for rising-edge detection.
  logic                  flap_prev_q;
  logic                  start_prev_q;

  logic flap_e;
  logic start_e;

  assign flap_e  = flap  & ~flap_prev_q;
  assign start_e = start & ~start_prev_q;

  // ---------------------------------------------------------------------------
  // One flight step. Shared by the READY launch (base = spawn point, flap
  // forced) and by normal FLY ticks, so a launch goes through the same
  // ceiling/floor clamps as any other tick.
  // ---------------------------------------------------------------------------
  logic                  launch;
  logic                  mot_flap;
  logic [Y_W-1:0]        mot_y_base;
  logic signed [V_W-1:0] mot_v_base;
  logic signed [V_W:0]   vel_grav;
  logic signed [V_W-1:0] vel_n;
  logic signed [P_W-1:0] y_base_x;
  logic signed [P_W-1:0] vel_n_x;
  logic signed [P_W-1:0] y_n;
  logic                  at_floor;
  logic                  at_ceil;

  assign launch     = (state_q != ST_FLY) && (state_q != ST_DEAD) && (flap_e || start_e);
  assign mot_flap   = launch ? 1'b1 : flap_e;
  assign mot_y_base = launch ? Y_INIT_C : y_q;
  assign mot_v_base = launch ? VEL_ZERO : vel_q;

  // Gravity is added one bit wider so the terminal-velocity compare sees the
  // true sum even when vel + GRAVITY would overflow V_W.
  assign vel_grav = {mot_v_base[V_W-1], mot_v_base} + GRAVITY_X;

  always_comb begin
    vel_n = vel_grav[V_W-1:0];
    if (mot_flap) begin
      vel_n = VEL_FLAP;
    end else if (vel_grav > VEL_MAX_X) begin
      vel_n = VEL_MAX_C;
    end
  end

  assign y_base_x = $signed({2'b00, mot_y_base});
  assign vel_n_x  = {{(P_W-V_W){vel_n[V_W-1]}}, vel_n};
  assign y_n      = y_base_x + vel_n_x;

  // Floor is tested first so it wins if both ever hold at once.
  assign at_floor = (y_n >= Y_MAX_X);
  assign at_ceil  = (y_n <= Y_MIN_X);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    hit_d   = 1'b0;

    case (state_q)
      ST_FLY: begin
        if (game_end) begin
          // Killed by the game FSM: freeze where we are, no ground impact.
          state_d = ST_DEAD;
        end else if (at_floor) begin
          state_d = ST_DEAD;
          y_d     = Y_MAX_C;
          vel_d   = VEL_ZERO;
          hit_d   = 1'b1;
        end else if (at_ceil) begin
          y_d     = Y_MIN_C;
          vel_d   = VEL_ZERO;
        end else begin
          y_d     = y_n[Y_W-1:0];
          vel_d   = vel_n;
        end
      end

      ST_DEAD: begin
        // Outputs hold; only a start edge re-arms.
        if (start_e) begin
          state_d = ST_READY;
          y_d     = Y_INIT_C;
          vel_d   = VEL_ZERO;
        end
      end

      default: begin
        // READY (and the unused code 3): parked at the spawn point,
        // game_end is ignored here.
        state_d = ST_READY;
        y_d     = Y_INIT_C;
        vel_d   = VEL_ZERO;
        if (launch) begin
          if (at_floor) begin
            state_d = ST_DEAD;
            y_d     = Y_MAX_C;
            vel_d   = VEL_ZERO;
            hit_d   = 1'b1;
          end else if (at_ceil) begin
            state_d = ST_FLY;
            y_d     = Y_MIN_C;
            vel_d   = VEL_ZERO;
          end else begin
            state_d = ST_FLY;
            y_d     = y_n[Y_W-1:0];
            vel_d   = vel_n;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. The edge-detect history is cleared by clr, so a button held
  // across reset release counts as a fresh edge on the first tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk10 or posedge clr) begin
    if (clr) begin
      state_q      <= ST_READY;
      y_q          <= Y_INIT_C;
      vel_q        <= VEL_ZERO;
      hit_q        <= 1'b0;
      flap_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      vel_q        <= vel_d;
      hit_q        <= hit_d;
      flap_prev_q  <= flap;
      start_prev_q <= start;
    end
  end

  assign bird_y_pos = y_q;
  assign bird_vel   = vel_q;
  assign state      = state_q;
  assign hit_ground = hit_q;

endmodule

// File: tb/tb_bird_motion.sv
// Purpose: self-checking bench for bird_motion: vector table, scripted corner cases, random vs model.
// Latency: outputs checked 1 time unit after each clk10 rising edge.
// Backpressure: none.
module tb_bird_motion;

  logic              clk10 = 1'b0;
  logic              clr;
  logic              game_end;
  logic              flap;
  logic              start;
  logic [9:0]        bird_y_pos;
  logic signed [5:0] bird_vel;
  logic [1:0]        state;
  logic              hit_ground;

  // Second instance spawned near the ceiling.
  logic              game_end2;
  logic              flap2;
  logic              start2;
  logic [9:0]        y2;
  logic signed [5:0] v2;
  logic [1:0]        s2;
  logic              h2;

  always #5 clk10 = ~clk10;

  bird_motion dut (
    .clk10(clk10), .clr(clr), .game_end(game_end), .flap(flap), .start(start),
    .bird_y_pos(bird_y_pos), .bird_vel(bird_vel), .state(state), .hit_ground(hit_ground)
  );

  bird_motion #(.Y_INIT(20)) dut_ceil (
    .clk10(clk10), .clr(clr), .game_end(game_end2), .flap(flap2), .start(start2),
    .bird_y_pos(y2), .bird_vel(v2), .state(s2), .hit_ground(h2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers following the game rules.
  localparam int READY = 0, FLY = 1, DEAD = 2;
  int m_state, m_y, m_v, m_hit;
  bit m_fp, m_sp;

  function automatic void model_reset();
    m_state = READY; m_y = 240; m_v = 0; m_hit = 0; m_fp = 0; m_sp = 0;
  endfunction

  function automatic void model_fly(bit do_flap, int base_y, int base_v);
    int vn, yn;
    vn = do_flap ? -8 : ((base_v + 1 > 12) ? 12 : base_v + 1);
    yn = base_y + vn;
    if (yn >= 465) begin
      m_y = 465; m_v = 0; m_hit = 1; m_state = DEAD;
    end else if (yn <= 15) begin
      m_y = 15; m_v = 0; m_state = FLY;
    end else begin
      m_y = yn; m_v = vn; m_state = FLY;
    end
  endfunction

  function automatic void model_step(bit ge, bit fl, bit st);
    bit fe, se;
    fe = fl && !m_fp;
    se = st && !m_sp;
    m_fp = fl; m_sp = st; m_hit = 0;
    if (m_state == READY) begin
      if (fe || se) model_fly(1'b1, 240, 0);
    end else if (m_state == FLY) begin
      if (ge) m_state = DEAD;
      else model_fly(fe, m_y, m_v);
    end else begin
      if (se) begin m_state = READY; m_y = 240; m_v = 0; end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int y, input int v, input int s, input int h);
    chk({tag, "_y"}, int'(bird_y_pos), y);
    chk({tag, "_vel"}, int'(bird_vel), v);
    chk({tag, "_state"}, int'(state), s);
    chk({tag, "_hit"}, int'(hit_ground), h);
  endtask

  task automatic chk_model(input string tag);
    chk_out(tag, m_y, m_v, m_state, m_hit);
  endtask

  // Apply inputs for one tick, advance the model, sample just after the edge.
  task automatic cycle(input bit ge, input bit fl, input bit st);
    game_end = ge; flap = fl; start = st;
    model_step(ge, fl, st);
    @(posedge clk10);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; game_end = 0; flap = 0; start = 0;
    model_reset();
    @(posedge clk10);
    @(negedge clk10);
    clr = 1'b0;
  endtask

  // One flap tick followed by n-1 idle ticks, every tick checked against the model.
  task automatic flap_seg(input int n, input string tag);
    cycle(0, 1, 0); chk_model(tag);
    for (int i = 1; i < n; i++) begin
      cycle(0, 0, 0); chk_model(tag);
    end
  endtask

  typedef struct {
    bit ge; bit fl; bit st;
    int y; int v; int s; int h;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int exp_tick, dut_tick, peak_v;

    game_end2 = 0; flap2 = 0; start2 = 0;
    clr = 1'b1; game_end = 0; flap = 0; start = 0;
    model_reset();
    #2;
    chk_out("reset", 240, 0, READY, 0);
    @(negedge clk10);
    clr = 1'b0;

    // ---- table-driven vectors from READY ----
    tbl[0]  = '{0, 1, 0, 232, -8, FLY,   0};  // flap edge launches
    tbl[1]  = '{0, 1, 0, 225, -7, FLY,   0};  // held flap: no new impulse
    tbl[2]  = '{0, 1, 0, 219, -6, FLY,   0};
    tbl[3]  = '{0, 1, 0, 214, -5, FLY,   0};
    tbl[4]  = '{0, 1, 0, 210, -4, FLY,   0};
    tbl[5]  = '{0, 0, 0, 207, -3, FLY,   0};
    tbl[6]  = '{0, 1, 0, 199, -8, FLY,   0};  // new edge
    tbl[7]  = '{0, 0, 1, 192, -7, FLY,   0};  // start ignored in FLY
    tbl[8]  = '{1, 1, 0, 192, -7, DEAD,  0};  // game_end beats flap
    tbl[9]  = '{0, 0, 0, 192, -7, DEAD,  0};
    tbl[10] = '{0, 1, 0, 192, -7, DEAD,  0};  // flap ignored in DEAD
    tbl[11] = '{0, 0, 1, 240,  0, READY, 0};  // re-arm
    tbl[12] = '{0, 0, 1, 240,  0, READY, 0};
    tbl[13] = '{1, 0, 0, 240,  0, READY, 0};  // game_end ignored in READY
    tbl[14] = '{0, 1, 1, 232, -8, FLY,   0};  // flap+start: one launch
    tbl[15] = '{0, 0, 0, 225, -7, FLY,   0};
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].ge, tbl[i].fl, tbl[i].st);
      chk_out($sformatf("vec%0d", i), tbl[i].y, tbl[i].v, tbl[i].s, tbl[i].h);
    end

    // ---- free fall from a start pulse ----
    do_reset();
    cycle(0, 0, 1);
    chk_out("fall_launch", 232, -8, FLY, 0);
    exp_tick = -1; dut_tick = -1; peak_v = -100;
    for (int i = 1; i < 200; i++) begin
      cycle(0, 0, 0);
      chk_model("fall");
      if (int'(bird_vel) > peak_v) peak_v = int'(bird_vel);
      if (hit_ground && dut_tick < 0) dut_tick = i;
      if (m_hit == 1) begin exp_tick = i; break; end
    end
    chk("fall_ticks", dut_tick, exp_tick);
    chk("fall_peak_vel", peak_v, 12);
    cycle(0, 0, 0);
    chk_out("fall_after", 465, 0, DEAD, 0);

    // ---- game_end with flap edge at y=300, vel=4 ----
    do_reset();
    cycle(0, 0, 1);
    for (int i = 1; i < 26; i++) begin cycle(0, 0, 0); chk_model("ge_path"); end
    flap_seg(16, "ge_seg1");
    flap_seg(16, "ge_seg2");
    flap_seg(13, "ge_seg3");
    chk_out("ge_pre", 300, 4, FLY, 0);
    cycle(1, 1, 0);
    chk_out("ge_kill", 300, 4, DEAD, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, i[0], 0);
      chk_out("ge_hold", 300, 4, DEAD, 0);
    end

    // ---- restart ----
    cycle(0, 0, 1);
    chk_out("restart_ready", 240, 0, READY, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk_out("restart_fly", 232, -8, FLY, 0);

    // ---- asynchronous clr mid-flight at y=350, vel=9 ----
    do_reset();
    cycle(0, 0, 1);
    for (int i = 1; i < 25; i++) begin cycle(0, 0, 0); chk_model("clr_path"); end
    flap_seg(16, "clr_seg1");
    flap_seg(19, "clr_seg2");
    flap_seg(18, "clr_seg3");
    chk_out("clr_pre", 350, 9, FLY, 0);
    #3 clr = 1'b1;
    #1;
    chk_out("clr_async", 240, 0, READY, 0);
    model_reset();
    @(posedge clk10);
    @(negedge clk10);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      chk_out("clr_idle", 240, 0, READY, 0);
    end
    // flap held across clr release counts as an edge
    clr = 1'b1; flap = 1'b1;
    model_reset();
    @(negedge clk10);
    clr = 1'b0;
    cycle(0, 1, 0);
    chk_out("clr_flap_held", 232, -8, FLY, 0);

    // ---- ceiling clamp (Y_INIT = 20) ----
    flap2 = 1'b1;
    @(posedge clk10); #1;
    chk("ceil_y", int'(y2), 15);
    chk("ceil_vel", int'(v2), 0);
    chk("ceil_state", int'(s2), FLY);
    flap2 = 1'b0;
    @(posedge clk10); #1;
    chk("ceil_next_y", int'(y2), 16);
    chk("ceil_next_vel", int'(v2), 1);
    @(posedge clk10); #1;
    chk("ceil_next2_y", int'(y2), 18);

    // ---- random stimulus vs model ----
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 clr = 1'b1;
        #1;
        model_reset();
        chk_model("rand_clr");
        #1 clr = 1'b0;
      end
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
